uart_tx: RTL and testbench

UART transmitter for the controller board: serialises bytes as 8N1 frames (optionally 8E1) on `TxD` at a fixed baud rate derived from the system clock. It pairs with the team's UART receiver on the remote board and uses the same line format, LSB-first ordering, 65 MHz clock and 9600 baud defaults. A one-byte holding register in front of the shifter lets the paddle/game logic queue the next byte while the current frame is on the line, so consecutive frames go out with no idle gap.

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8N1 frames LSB first, with a one-byte holding register for gapless back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx #(
    parameter int CLK_FREQ  = 65_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       TxD,
    output logic       busy,
    output logic       tx_done
);

    localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic          r_txd;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    state_t        w_state_next;
    logic [CW-1:0] w_baud_next;
    logic [2:0]    w_bit_next;
    logic [7:0]    w_shift_next;
    logic          w_load;
    logic          w_bit_end;
    logic          w_txd_next;

    always_comb begin
        w_bit_end    = (r_baud_cnt == BAUD_LAST);
        w_state_next = r_state;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_baud_next  = '0;
        w_txd_next   = 1'b1;

        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_state_next = START;
                    w_load       = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_next   = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) w_state_next = STOP;
            end
`endif
            STOP: begin
                // Reload straight from the holding register so the next start bit follows with no idle cycle
                if (w_bit_end) begin
                    if (r_hold_full) begin
                        w_state_next = START;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_load) w_shift_next = r_hold;

        if (r_state != IDLE && !w_bit_end && w_state_next == r_state)
            w_baud_next = r_baud_cnt + 1'b1;

        // TxD is registered, so it is driven from the state being entered
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_txd_next = r_parity;
`endif
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            if (w_load) r_parity <= ^r_hold;
`endif
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (in_valid && !r_hold_full) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign in_ready = !r_hold_full;
    assign TxD      = r_txd;
    assign busy     = (r_state != IDLE);
    assign tx_done  = (r_state == STOP) && w_bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx at a reduced baud divider (10 cycles per bit).
// Builds for either frame format, following UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int D      = 10;
    localparam int PERIOD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       TxD;
    logic       busy;
    logic       tx_done;

    always #(PERIOD/2) clk = ~clk;

    uart_tx #(
        .CLK_FREQ (1000),
        .BAUD_RATE(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .TxD     (TxD),
        .busy    (busy),
        .tx_done (tx_done)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t   vecs[8];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic [7:0] cap_data[$];
    logic       cap_par[$];
    longint     cap_fall[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line-side UART model: finds each start bit, samples bit centres, watches tx_done and busy.
    task automatic capture(input int nframes);
        int         w;
        bit         found;
        logic [10:0] bits;
        int         hits;
        int         pos;
        int         busy_bad;
        for (int f = 0; f < nframes; f++) begin
            w = 0; found = 0; bits = '1; hits = 0; pos = -1; busy_bad = 0;
            while (!found && w < 4*NB*D) begin
                @(negedge clk);
                if (TxD === 1'b0) found = 1;
                else w++;
            end
            if (!found) begin
                chk("frame_start_timeout", 0, 1);
                return;
            end
            cap_fall.push_back($time / PERIOD);
            for (int off = 0; off < NB*D; off++) begin
                if (off > 0) @(negedge clk);
                if (off % D == D/2) bits[off / D] = TxD;
                if (tx_done === 1'b1) begin hits++; pos = off; end
                if (busy !== 1'b1) busy_bad++;
            end
            chk("start_bit", bits[0], 0);
            chk("stop_bit", bits[NB-1], 1);
            chk("tx_done_count", hits, 1);
            chk("tx_done_pos", pos, NB*D-1);
            chk("busy_in_frame", busy_bad, 0);
            cap_data.push_back(bits[8:1]);
            cap_par.push_back(bits[9]);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic offer(input logic [7:0] d, output longint t_acc);
        int w = 0;
        in_data  = d;
        in_valid = 1'b1;
        t_acc    = -1;
        while (in_ready !== 1'b1 && w < 4*NB*D) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
    endtask

    task automatic clear_capture();
        cap_data.delete();
        cap_par.delete();
        cap_fall.delete();
    endtask

    task automatic send_check(input logic [7:0] d, input logic par);
        longint ta;
        clear_capture();
        fork
            capture(1);
            begin
                offer(d, ta);
                @(negedge clk);
                in_valid = 1'b0;
                chk($sformatf("%02h_txd_after_accept", d), TxD, 1);
                chk($sformatf("%02h_ready_after_accept", d), in_ready, 0);
                chk($sformatf("%02h_busy_after_accept", d), busy, 0);
                @(negedge clk);
                chk($sformatf("%02h_txd_start", d), TxD, 0);
                chk($sformatf("%02h_busy_start", d), busy, 1);
                chk($sformatf("%02h_ready_after_load", d), in_ready, 1);
            end
        join
        chk($sformatf("%02h_frames", d), cap_data.size(), 1);
        if (cap_data.size() == 1) begin
            chk($sformatf("%02h_data", d), cap_data[0], d);
`ifdef UART_TX_PARITY_EN
            chk($sformatf("%02h_parity", d), cap_par[0], par);
`endif
        end
        @(negedge clk);
        chk($sformatf("%02h_busy_after", d), busy, 0);
        chk($sformatf("%02h_txd_after", d), TxD, 1);
    endtask

    initial begin
        #(200_000 * PERIOD);
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        longint t1, t2, t3;
        int     bad;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'hA5, 1'b0};
        vecs[2] = '{8'h3C, 1'b0};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h03, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h00, 1'b0};
        vecs[7] = '{8'h80, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", TxD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (TxD !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk("idle_line", bad, 0);

        foreach (vecs[i]) send_check(vecs[i].data, vecs[i].par);

        // Back-to-back: second byte offered on the edge after the first is accepted
        clear_capture();
        fork
            capture(2);
            begin
                offer(8'hA5, t1);
                @(negedge clk);
                offer(8'h3C, t2);
                @(negedge clk);
                in_valid = 1'b0;
            end
        join
        chk("b2b_accept_gap", (t2 - t1) / PERIOD, 2);
        chk("b2b_frames", cap_data.size(), 2);
        if (cap_data.size() == 2) begin
            chk("b2b_data0", cap_data[0], 8'hA5);
            chk("b2b_data1", cap_data[1], 8'h3C);
            chk("b2b_frame_gap", cap_fall[1] - cap_fall[0], NB*D);
        end
        repeat (2) @(negedge clk);

        // Backpressure: producer keeps offering while the holding register is full
        clear_capture();
        fork
            capture(3);
            begin
                offer(8'h11, t1);
                @(negedge clk);
                offer(8'h22, t2);
                @(negedge clk);
                chk("bp_ready_low", in_ready, 0);
                offer(8'h33, t3);
                @(negedge clk);
                in_valid = 1'b0;
            end
        join
        chk("bp_frames", cap_data.size(), 3);
        if (cap_data.size() == 3) begin
            chk("bp_data0", cap_data[0], 8'h11);
            chk("bp_data1", cap_data[1], 8'h22);
            chk("bp_data2", cap_data[2], 8'h33);
            chk("bp_gap01", cap_fall[1] - cap_fall[0], NB*D);
            chk("bp_gap12", cap_fall[2] - cap_fall[1], NB*D);
        end
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of 0xF0, with 0x5A waiting in the holding register
        offer(8'hF0, t1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("f0_start", TxD, 0);
        offer(8'h5A, t2);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4*D + D/2 - 1) @(negedge clk);
        chk("f0_bit3", TxD, 0);
        chk("f0_hold_full", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", TxD, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        rst = 1'b0;
        bad = 0;
        repeat (3*NB*D) begin
            @(negedge clk);
            if (TxD !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("midrst_hold_discarded", bad, 0);
        send_check(8'h81, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
